// File: rtl/meduram_pkg.sv
// meduram_pkg: shared types and helpers for the meduram read-stream block.
//   state_e  : reader FSM states (idle / issuing reads / draining returns).
//   wrap_inc : address increment that wraps at an arbitrary RAM depth.
package meduram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    // Increment with wrap at depth-1; also correct when depth is not a power of two.
    function automatic logic [31:0] wrap_inc(input logic [31:0] a, input int unsigned depth);
        if (a == depth - 1) begin
            return '0;
        end
        return a + 32'd1;
    endfunction

endpackage

// File: rtl/meduram_sync_fifo.sv
// meduram_sync_fifo: small synchronous FIFO, show-ahead read port.
//   clk       : clock, rising edge
//   srst      : synchronous active-high reset (pointers and count cleared)
//   push      : write push_data this cycle
//   push_data : entry to write
//   pop       : discard the head entry this cycle
//   pop_data  : current head entry (valid while empty=0)
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of stored entries
// Simultaneous push and pop is legal, including while full.
module meduram_sync_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        pop_data = mem_q[rd_ptr_q];
        full     = (count_q == CntW'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
    end

endmodule

// File: rtl/meduram_rd_stream.sv
// meduram_rd_stream: burst reader in front of one meduram RAM read port.
//   aclk, srst          : clock (rising edge) and synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; cmd_addr = start, cmd_len = word count
//   rden, rdaddr        : RAM read request, one address per cycle
//   rddata              : RAM read data, valid the cycle after rden
//   out_valid/out_ready : output word handshake; out_data word, out_last final word
//   busy                : a command is in progress
// Reads are issued only while FIFO occupancy plus the in-flight read leaves room,
// so returning data always has a slot even under full backpressure.
module meduram_rd_stream
    import meduram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  rden,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] rddata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned LenW = ADDR_WIDTH + 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CrW  = CntW + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LenW-1:0]       remaining_q;   // reads still to issue
    logic [LenW-1:0]       deliver_q;     // words still to hand downstream
    logic                  inflight_q;    // rden was high last cycle
    logic                  inflight_last_q;

    logic                  cmd_fire;
    logic                  out_fire;
    logic                  last_fire;
    logic                  credit_ok;
    logic [CrW-1:0]        credit_used;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CntW-1:0]       fifo_count;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire && (cmd_len != '0)) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (rden && (remaining_q == LenW'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave on the final handshake so cmd_ready rises the very next cycle.
                if (last_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        rden      = (state_q == StIssue) && credit_ok;
        rdaddr    = addr_q;
    end

    // ------------------------------------------------------------------
    // Credit and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        credit_used = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
        credit_ok   = (credit_used < CrW'(FIFO_DEPTH));
        cmd_fire    = cmd_valid && cmd_ready;
        out_fire    = out_valid && out_ready;
        last_fire   = out_fire && (deliver_q == LenW'(1));
    end

    // ------------------------------------------------------------------
    // Address, length and delivery counters
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (srst) begin
            addr_q          <= '0;
            remaining_q     <= '0;
            deliver_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            // Clearing inflight on reset drops RAM data returning just after it.
            inflight_q      <= rden;
            inflight_last_q <= rden && (remaining_q == LenW'(1));

            if (cmd_fire) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_len;
            end else if (rden) begin
                addr_q      <= ADDR_WIDTH'(wrap_inc(32'(addr_q), RAM_DEPTH));
                remaining_q <= remaining_q - LenW'(1);
            end

            if (cmd_fire) begin
                deliver_q <= cmd_len;
            end else if (out_fire) begin
                deliver_q <= deliver_q - LenW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO with fall-through bypass: when the FIFO is empty the
    // returning word is presented directly and only stored if not taken.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_push = inflight_q && !(fifo_empty && out_ready);
        fifo_pop  = !fifo_empty && out_ready;
        out_valid = !fifo_empty || inflight_q;
        out_data  = fifo_empty ? rddata : fifo_head[DATA_WIDTH-1:0];
        out_last  = out_valid && (deliver_q == LenW'(1));
    end

    meduram_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .srst      (srst),
        .push      (fifo_push),
        .push_data ({inflight_last_q, rddata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
    cmd_legal_a: assert property (@(posedge aclk) disable iff (srst)
        cmd_fire |-> (({1'b0, cmd_addr} < LenW'(RAM_DEPTH)) && (cmd_len <= LenW'(RAM_DEPTH))));

    fifo_no_overflow_a: assert property (@(posedge aclk) disable iff (srst)
        fifo_push |-> (!fifo_full || fifo_pop));

    // The tag carried with each word must agree with the delivery counter.
    last_agree_a: assert property (@(posedge aclk) disable iff (srst)
        out_valid |-> (out_last == (fifo_empty ? inflight_last_q : fifo_head[DATA_WIDTH])));

endmodule
